// File: rtl/mutation_gene_packer_if.sv
// Gene packer stream bundle: 3-lane gene input side plus 1-gene/cycle output side and genome report.
// slave = packer view, master = producer/consumer view.
interface mutation_gene_packer_if #(
    parameter int GENE_SZ = 64,
    parameter int ATTR_SZ = 8
);
    logic [GENE_SZ-1:0] gene_in1;
    logic [GENE_SZ-1:0] gene_in2;
    logic [GENE_SZ-1:0] gene_in3;
    logic [2:0]         in_valid;
    logic               in_last;
    logic               in_ready;
    logic               overflow;
    logic [GENE_SZ-1:0] gene_out;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;
    logic               genome_done;
    logic [ATTR_SZ-1:0] genome_len;

    modport slave (
        input  gene_in1, gene_in2, gene_in3, in_valid, in_last, out_ready,
        output in_ready, overflow, gene_out, out_last, out_valid, genome_done, genome_len
    );

    modport master (
        output gene_in1, gene_in2, gene_in3, in_valid, in_last, out_ready,
        input  in_ready, overflow, gene_out, out_last, out_valid, genome_done, genome_len
    );
endinterface

// File: rtl/mutation_gene_packer.sv
// Compacts up to 3 genes/cycle into a FIFO and drains 1/cycle; 1-cycle push-to-head latency.
// in_ready drops below 3 free entries (registered occupancy); groups arriving while not ready are dropped and flag overflow.
module mutation_gene_packer #(
    parameter int GENE_SZ = 64,
    parameter int ATTR_SZ = 8,
    parameter int DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mutation_gene_packer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_MASK = PW'(DEPTH - 1);

    logic [GENE_SZ:0] mem [DEPTH];

    logic [PW-1:0]      wr_ptr, rd_ptr, count_q;
    logic [ATTR_SZ-1:0] len_cnt;
    logic               overflow_q, done_q;
    logic [ATTR_SZ-1:0] len_q;

    logic [2:0]       v;
    logic [1:0]       n_push;
    logic             has_grp, accept, pop, not_empty;
    logic [PW:0]      free_cnt;
    logic [GENE_SZ:0] l1, l2, l3, e0, e1, e2, head;
    logic [AW-1:0]    wi0, wi1, wi2;

    assign v        = bus.in_valid;
    assign n_push   = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    assign has_grp  = |v;
    assign free_cnt = (PW+1)'(DEPTH) - {1'b0, count_q};
    assign bus.in_ready = (free_cnt >= (PW+1)'(3));
    assign accept   = has_grp & bus.in_ready;

    // Only the highest-numbered valid lane may carry the genome-closing mark.
    assign l1 = {bus.in_last & ~v[1] & ~v[2], bus.gene_in1};
    assign l2 = {bus.in_last & ~v[2],         bus.gene_in2};
    assign l3 = {bus.in_last,                 bus.gene_in3};

    assign e0 = v[0] ? l1 : (v[1] ? l2 : l3);
    assign e1 = (v[0] & v[1]) ? l2 : l3;
    assign e2 = l3;

    assign wi0 = wr_ptr[AW-1:0];
    assign wi1 = wi0 + AW'(1);
    assign wi2 = wi0 + AW'(2);

    assign not_empty = (count_q != '0);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign pop       = not_empty & bus.out_ready;

    assign bus.out_valid   = not_empty;
    assign bus.gene_out    = not_empty ? head[GENE_SZ-1:0] : '0;
    assign bus.out_last    = not_empty & head[GENE_SZ];
    assign bus.overflow    = overflow_q;
    assign bus.genome_done = done_q;
    assign bus.genome_len  = len_q;

    // Storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wi0] <= e0;
            if (n_push >= 2'd2) mem[wi1] <= e1;
            if (n_push == 2'd3) mem[wi2] <= e2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            len_cnt    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept)
                wr_ptr <= (wr_ptr + PW'(n_push)) & PTR_MASK;
            if (pop)
                rd_ptr <= (rd_ptr + PW'(1)) & PTR_MASK;
            count_q <= count_q + (accept ? PW'(n_push) : '0) - PW'(pop);
            if (has_grp && !bus.in_ready)
                overflow_q <= 1'b1;
            if (pop) begin
                if (head[GENE_SZ]) begin
                    done_q  <= 1'b1;
                    len_q   <= len_cnt + ATTR_SZ'(1);
                    len_cnt <= '0;
                end else begin
                    len_cnt <= len_cnt + ATTR_SZ'(1);
                end
            end
        end
    end
endmodule
